id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand/result data width; the block SHALL be verified at 32.
REQ-002 Parameter CNT_W, default 16, width of issue counter.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  decode stage offers an instruction.
REQ-006 in_ready  output  1  block can accept this cycle.
REQ-007 rs1_val, rs2_val  input  WIDTH each  register-file read data.
REQ-008 imm  input  WIDTH  sign-extended immediate; use_imm  input  1  selects imm for ALU operand 2.
REQ-009 rs1_idx, rs2_idx, rd_idx  input  5 each  source/destination register numbers.
REQ-010 alu_sel  input  6  ALU select bits; bit i drives ALU sel<i> (bit 5 = logical/arith choice).
REQ-011 flush  input  1  discard all held and offered instructions.
REQ-012 fwd_exm_en, fwd_exm_rd[4:0], fwd_exm_data[WIDTH]  inputs  EX/MEM forwarding source.
REQ-013 fwd_mwb_en, fwd_mwb_rd[4:0], fwd_mwb_data[WIDTH]  inputs  MEM/WB forwarding source.
REQ-014 out_valid  output  1  ALU-stage inputs valid; out_ready  input  1  execute stage consumes.
REQ-015 out_in1, out_in2  output  WIDTH each  ALU operands; out_sel  output  6; out_rd  output  5.
REQ-016 issue_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-017 Capture SHALL occur iff in_valid && in_ready && !flush; output handshake iff out_valid && out_ready.
REQ-018 Operand resolution at capture: source idx == 0 -> 0; else idx == fwd_exm_rd with fwd_exm_en -> fwd_exm_data; else idx == fwd_mwb_rd with fwd_mwb_en -> fwd_mwb_data; else register-file value.
REQ-019 EX/MEM forward SHALL take priority over MEM/WB when both match.
REQ-020 Operand 2 = imm when use_imm=1 (no forwarding applied); else resolved rs2.
REQ-021 Storage: main register M (drives all out_* ports) and skid register S; states EMPTY, ONE, TWO.
REQ-022 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO.
REQ-023 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-024 EMPTY: capture -> load M, go ONE; else stay.
REQ-025 ONE: capture and out_ready -> load M, stay ONE; capture and !out_ready -> load S, go TWO; no capture and out_ready -> EMPTY; else stay.
REQ-026 TWO: out_ready -> M <= S, go ONE; else hold; no capture possible.
REQ-027 Latency: captured instruction SHALL appear on out_* the cycle after capture when M is free or being consumed; order SHALL be strictly preserved.
REQ-028 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 flush SHALL force next state EMPTY, drop M and S, block capture that cycle; it takes precedence over every other event including a same-cycle output handshake (handshake still counted).
REQ-030 issue_cnt SHALL increment by 1 per output handshake, wrapping 2^CNT_W-1 -> 0.
REQ-031 Load-use hazards are resolved by the upstream hazard unit; this block SHALL not stall for them.

Reset
REQ-032 While rst_n=0: state EMPTY, in_ready=1, out_valid=0, out_in1=out_in2=0, out_sel=0, out_rd=0, issue_cnt=0, S cleared.
REQ-033 Reset assertion mid-operation SHALL discard held instructions immediately, without waiting for clk.
REQ-034 First capture possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 rs1_idx=3, fwd_exm_en=1 rd=3 data=0x11, fwd_mwb_en=1 rd=3 data=0x22, rf=0x33 -> out_in1=0x11 next cycle.
REQ-036 rs1_idx=0, fwd_exm_en=1 rd=0 data=0xFF -> out_in1=0; use_imm=1 imm=0xFFFFFFF0 -> out_in2=0xFFFFFFF0.
REQ-037 out_ready=0, three back-to-back in_valid -> A in M, B in S, in_ready=0 third cycle, C not taken; out_ready=1 -> A, B, then C in order.
REQ-038 State TWO, flush=1 with out_ready=1 -> next cycle out_valid=0, in_ready=1, issue_cnt +1.
REQ-039 issue_cnt=0xFFFF, one output handshake -> issue_cnt=0x0000.
REQ-040 rst_n low between edges while out_valid=1 -> out_valid=0 and out_in1=0 immediately, before next edge.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake bundle: operand sources and forwarding inputs in,
// resolved ALU operands out, plus the completed-issue counter.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] imm;
    logic             use_imm;
    logic [4:0]       rs1_idx;
    logic [4:0]       rs2_idx;
    logic [4:0]       rd_idx;
    logic [5:0]       alu_sel;
    logic             flush;
    logic             fwd_exm_en;
    logic [4:0]       fwd_exm_rd;
    logic [WIDTH-1:0] fwd_exm_data;
    logic             fwd_mwb_en;
    logic [4:0]       fwd_mwb_rd;
    logic [WIDTH-1:0] fwd_mwb_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_in1;
    logic [WIDTH-1:0] out_in2;
    logic [5:0]       out_sel;
    logic [4:0]       out_rd;
    logic [CNT_W-1:0] issue_cnt;

    modport master (
        output in_valid, rs1_val, rs2_val, imm, use_imm, rs1_idx, rs2_idx, rd_idx,
               alu_sel, flush, fwd_exm_en, fwd_exm_rd, fwd_exm_data,
               fwd_mwb_en, fwd_mwb_rd, fwd_mwb_data, out_ready,
        input  in_ready, out_valid, out_in1, out_in2, out_sel, out_rd, issue_cnt
    );

    modport slave (
        input  in_valid, rs1_val, rs2_val, imm, use_imm, rs1_idx, rs2_idx, rd_idx,
               alu_sel, flush, fwd_exm_en, fwd_exm_rd, fwd_exm_data,
               fwd_mwb_en, fwd_mwb_rd, fwd_mwb_data, out_ready,
        output in_ready, out_valid, out_in1, out_in2, out_sel, out_rd, issue_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and a one-entry skid buffer.
// Latency: 1 cycle from capture to out_* when the main register is free or draining.
// Backpressure: registered in_ready drops only when both main and skid entries are full.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
        logic [5:0]       sel;
        logic [4:0]       rd;
    } ex_op_t;

    state_t           state_q;
    state_t           state_nxt;
    ex_op_t           m_q;
    ex_op_t           s_q;
    ex_op_t           cap_op;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             capture;
    logic             handshake;
    logic             load_m;
    logic             load_s;
    logic             m_from_s;

    // Register 0 reads as zero; the younger EX/MEM result wins over MEM/WB.
    function automatic logic [WIDTH-1:0] resolve(
        input logic [4:0]       idx,
        input logic [WIDTH-1:0] rf_val,
        input logic             exm_en,
        input logic [4:0]       exm_rd,
        input logic [WIDTH-1:0] exm_data,
        input logic             mwb_en,
        input logic [4:0]       mwb_rd,
        input logic [WIDTH-1:0] mwb_data
    );
        logic [WIDTH-1:0] r;
        if (idx == 5'd0)
            r = '0;
        else if (exm_en && idx == exm_rd)
            r = exm_data;
        else if (mwb_en && idx == mwb_rd)
            r = mwb_data;
        else
            r = rf_val;
        return r;
    endfunction

    assign capture   = bus.in_valid && in_ready_q && !bus.flush;
    assign handshake = out_valid_q && bus.out_ready;

    always_comb begin
        cap_op     = '0;
        cap_op.in1 = resolve(bus.rs1_idx, bus.rs1_val,
                             bus.fwd_exm_en, bus.fwd_exm_rd, bus.fwd_exm_data,
                             bus.fwd_mwb_en, bus.fwd_mwb_rd, bus.fwd_mwb_data);
        cap_op.in2 = bus.use_imm ? bus.imm
                   : resolve(bus.rs2_idx, bus.rs2_val,
                             bus.fwd_exm_en, bus.fwd_exm_rd, bus.fwd_exm_data,
                             bus.fwd_mwb_en, bus.fwd_mwb_rd, bus.fwd_mwb_data);
        cap_op.sel = bus.alu_sel;
        cap_op.rd  = bus.rd_idx;
    end

    // State register; ready/valid flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            in_ready_q  <= (state_nxt != TWO);
            out_valid_q <= (state_nxt != EMPTY);
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (capture) state_nxt = ONE;
                ONE: begin
                    if (capture && !bus.out_ready)
                        state_nxt = TWO;
                    else if (!capture && bus.out_ready)
                        state_nxt = EMPTY;
                end
                TWO:     if (bus.out_ready) state_nxt = ONE;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        if (!bus.flush) begin
            case (state_q)
                EMPTY: load_m = capture;
                ONE: begin
                    load_m = capture && bus.out_ready;
                    load_s = capture && !bus.out_ready;
                end
                TWO:     m_from_s = bus.out_ready;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
        end else begin
            if (load_m)
                m_q <= cap_op;
            else if (m_from_s)
                m_q <= s_q;
            if (load_s)
                s_q <= cap_op;
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, handshake};
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_in1   = m_q.in1;
    assign bus.out_in2   = m_q.in2;
    assign bus.out_sel   = m_q.sel;
    assign bus.out_rd    = m_q.rd;
    assign bus.issue_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed corner cases plus random traffic against a
// queue-based reference model of the ordered two-entry stage.
module tb_id_ex_stage;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [5:0]  sel;
        logic [4:0]  rd;
    } ex_t;

    logic  clk;
    logic  rst_n;
    ex_t   q[$];
    logic [15:0] m_cnt;
    logic [15:0] cnt_save;
    int    n_chk;
    int    n_pass;

    id_ex_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();

    id_ex_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'd0;
        if (bus.fwd_exm_en && idx == bus.fwd_exm_rd) return bus.fwd_exm_data;
        if (bus.fwd_mwb_en && idx == bus.fwd_mwb_rd) return bus.fwd_mwb_data;
        return rf;
    endfunction

    function automatic ex_t offered_op();
        ex_t op;
        op.in1 = src_val(bus.rs1_idx, bus.rs1_val);
        op.in2 = bus.use_imm ? bus.imm : src_val(bus.rs2_idx, bus.rs2_val);
        op.sel = bus.alu_sel;
        op.rd  = bus.rd_idx;
        return op;
    endfunction

    task automatic compare_all();
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, q.size() < 2});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() > 0});
        chk("issue_cnt", {48'd0, bus.issue_cnt}, {48'd0, m_cnt});
        if (q.size() > 0) begin
            chk("out_in1", {32'd0, bus.out_in1}, {32'd0, q[0].in1});
            chk("out_in2", {32'd0, bus.out_in2}, {32'd0, q[0].in2});
            chk("out_sel", {58'd0, bus.out_sel}, {58'd0, q[0].sel});
            chk("out_rd",  {59'd0, bus.out_rd},  {59'd0, q[0].rd});
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then check.
    task automatic step(input bit do_chk);
        bit  cap;
        bit  hs;
        ex_t op;
        @(posedge clk);
        cap = bus.in_valid && (q.size() < 2) && !bus.flush;
        hs  = (q.size() > 0) && bus.out_ready;
        op  = offered_op();
        if (hs) m_cnt = m_cnt + 16'd1;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (hs) void'(q.pop_front());
            if (cap) q.push_back(op);
        end
        #1;
        if (do_chk) compare_all();
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.rs1_val = 0; bus.rs2_val = 0; bus.imm = 0;
        bus.use_imm = 0; bus.rs1_idx = 0; bus.rs2_idx = 0; bus.rd_idx = 0;
        bus.alu_sel = 0; bus.flush = 0; bus.out_ready = 0;
        bus.fwd_exm_en = 0; bus.fwd_exm_rd = 0; bus.fwd_exm_data = 0;
        bus.fwd_mwb_en = 0; bus.fwd_mwb_rd = 0; bus.fwd_mwb_data = 0;
    endtask

    task automatic random_inputs();
        bus.in_valid     = ($urandom_range(0, 3) != 0);
        bus.out_ready    = ($urandom_range(0, 2) != 0);
        bus.flush        = ($urandom_range(0, 19) == 0);
        bus.use_imm      = $urandom_range(0, 1);
        bus.rs1_idx      = 5'($urandom_range(0, 3));
        bus.rs2_idx      = 5'($urandom_range(0, 3));
        bus.rd_idx       = 5'($urandom_range(0, 31));
        bus.alu_sel      = 6'($urandom_range(0, 63));
        bus.rs1_val      = $urandom;
        bus.rs2_val      = $urandom;
        bus.imm          = $urandom;
        bus.fwd_exm_en   = $urandom_range(0, 1);
        bus.fwd_exm_rd   = 5'($urandom_range(0, 3));
        bus.fwd_exm_data = $urandom;
        bus.fwd_mwb_en   = $urandom_range(0, 1);
        bus.fwd_mwb_rd   = 5'($urandom_range(0, 3));
        bus.fwd_mwb_data = $urandom;
    endtask

    initial begin
        int guard;
        n_chk = 0;
        n_pass = 0;
        m_cnt = 0;
        rst_n = 0;
        idle_inputs();
        #12;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_in1", {32'd0, bus.out_in1}, 64'd0);
        chk("rst_out_in2", {32'd0, bus.out_in2}, 64'd0);
        chk("rst_out_sel", {58'd0, bus.out_sel}, 64'd0);
        chk("rst_out_rd", {59'd0, bus.out_rd}, 64'd0);
        chk("rst_issue_cnt", {48'd0, bus.issue_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1;

        // EX/MEM beats MEM/WB beats register file; first edge after reset captures.
        bus.in_valid = 1; bus.rs1_idx = 3; bus.rs1_val = 32'h33;
        bus.fwd_exm_en = 1; bus.fwd_exm_rd = 3; bus.fwd_exm_data = 32'h11;
        bus.fwd_mwb_en = 1; bus.fwd_mwb_rd = 3; bus.fwd_mwb_data = 32'h22;
        step(1);
        chk("fwd_prio", {32'd0, bus.out_in1}, 64'h11);
        chk("first_valid", {63'd0, bus.out_valid}, 64'd1);

        // x0 ignores forwarding; immediate bypasses forwarding on operand 2.
        bus.out_ready = 1; bus.rs1_idx = 0; bus.fwd_exm_rd = 0; bus.fwd_exm_data = 32'hFF;
        bus.use_imm = 1; bus.imm = 32'hFFFF_FFF0; bus.rs2_idx = 3; bus.rs2_val = 32'h44;
        step(1);
        chk("x0_zero", {32'd0, bus.out_in1}, 64'd0);
        chk("imm_op2", {32'd0, bus.out_in2}, 64'hFFFF_FFF0);
        bus.in_valid = 0;
        step(1);

        // Three back-to-back offers with the consumer stalled.
        idle_inputs();
        bus.in_valid = 1; bus.rs1_idx = 5; bus.rs1_val = 32'hA;
        step(1);
        bus.rs1_val = 32'hB;
        step(1);
        chk("skid_full_rdy", {63'd0, bus.in_ready}, 64'd0);
        bus.rs1_val = 32'hC;
        step(1);
        chk("order_A", {32'd0, bus.out_in1}, 64'hA);
        bus.out_ready = 1;
        step(1);
        chk("order_B", {32'd0, bus.out_in1}, 64'hB);
        step(1);
        chk("order_C", {32'd0, bus.out_in1}, 64'hC);
        bus.in_valid = 0;
        step(1);
        chk("drained", {63'd0, bus.out_valid}, 64'd0);

        // Flush from TWO with a same-cycle handshake.
        bus.out_ready = 0; bus.in_valid = 1;
        step(1);
        step(1);
        cnt_save = m_cnt;
        bus.in_valid = 0; bus.flush = 1; bus.out_ready = 1;
        step(1);
        chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("flush_cnt", {48'd0, bus.issue_cnt}, {48'd0, cnt_save + 16'd1});
        bus.flush = 0;

        // Asynchronous reset between edges while holding an instruction.
        bus.in_valid = 1; bus.out_ready = 0; bus.rs1_idx = 7; bus.rs1_val = 32'h5A5A;
        step(1);
        bus.in_valid = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("arst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("arst_in1", {32'd0, bus.out_in1}, 64'd0);
        chk("arst_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("arst_cnt", {48'd0, bus.issue_cnt}, 64'd0);
        q.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 2000; i++) begin
            random_inputs();
            step(1);
        end

        // Stream to the counter wrap point.
        idle_inputs();
        bus.in_valid = 1; bus.out_ready = 1;
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            bus.rs1_val = $urandom;
            step(0);
            guard++;
        end
        chk("cnt_max", {48'd0, bus.issue_cnt}, 64'hFFFF);
        step(1);
        chk("cnt_wrap", {48'd0, bus.issue_cnt}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
